// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Owns the PC, issues one instruction-memory
// request at a time, hands the fetched word and its PC to decode over a
// valid/ready handshake, and squashes wrong-path fetches on redirect.
// Optional build macro: IFU_ALIGN_CHECK_EN. When it is defined, a misaligned PC
// produces a fault instruction without issuing a memory request.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state_q;
  logic [XLEN-1:0]   pc_q;
  logic              kill_q;
  logic [XLEN-1:0]   inst_q;
  logic [XLEN-1:0]   inst_pc_q;
  logic              inst_fault_q;
  logic              misalign_c;
  logic              req_fire_c;
  logic              out_fire_c;

  // Misaligned-PC detection, only present when the alignment check is built in
`ifdef IFU_ALIGN_CHECK_EN
  assign misalign_c = (pc_q[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Output decode; inst_valid is gated by redirect so no transfer completes in a redirect cycle
  assign imem_req_valid = (state_q == REQ) && !misalign_c;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == OUT) && !redirect_valid;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = inst_fault_q;
  assign req_fire_c     = imem_req_valid && imem_req_ready;
  assign out_fire_c     = inst_valid && inst_ready;

  // Fetch FSM with PC, kill flag and the instruction holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      inst_fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end else begin
            state_q <= REQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end
          if (req_fire_c) begin
            // A request accepted alongside a redirect is stale; its response gets dropped
            state_q <= WAIT;
            kill_q  <= redirect_valid;
          end else if (misalign_c && !redirect_valid) begin
            state_q      <= OUT;
            inst_q       <= '0;
            inst_pc_q    <= pc_q;
            inst_fault_q <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end
          if (imem_rsp_valid) begin
            kill_q <= 1'b0;
            if (kill_q || redirect_valid) begin
              state_q <= REQ;
            end else begin
              state_q      <= OUT;
              inst_q       <= imem_rsp_data;
              inst_pc_q    <= pc_q;
              inst_fault_q <= imem_rsp_err;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        OUT: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= REQ;
          end else if (out_fire_c) begin
            pc_q    <= pc_q + XLEN'(PC_STEP);
            state_q <= REQ;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios plus randomized traffic, checked
// against a stream-level model (expected PC sequence, address-derived memory contents).
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu_fetch #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_pc = RESET_PC;

  // memory model state: at most one accepted request awaiting its response
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          rsp_delay = 1;
  bit          rand_mode = 1'b0;

  bit          drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = '0;
  bit          drv_req_ready = 1'b1;
  bit          drv_inst_ready = 1'b1;

  logic [31:0] acc_addrs[$];
  logic [31:0] dlv_pcs[$];
  int          dlv_cyc[$];
  bit          dlv_fault[$];

  bit          s_inst_valid;
  bit          s_req_valid;
  logic [31:0] s_inst;
  logic [31:0] s_inst_pc;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return a[5:2] == 4'h4;
  endfunction

  function automatic logic misaligned(input logic [31:0] a);
`ifdef IFU_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive at negedge, observe just before posedge, advance model
  task automatic cycle();
    logic [31:0] want_inst;
    logic        want_fault;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = 1'($urandom_range(0, 1));
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data_fn(pend_addr);
        imem_rsp_err   = err_fn(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (rand_mode) begin
      drv_req_ready  = ($urandom_range(0, 9) < 7);
      drv_inst_ready = ($urandom_range(0, 9) < 6);
      drv_redirect   = ($urandom_range(0, 19) == 0);
      drv_redirect_pc = RESET_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
`ifdef IFU_ALIGN_CHECK_EN
      if ($urandom_range(0, 3) == 0) drv_redirect_pc[1:0] = 2'($urandom_range(1, 3));
`endif
    end
    imem_req_ready = drv_req_ready;
    inst_ready     = drv_inst_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    #3;
    s_inst_valid = inst_valid;
    s_req_valid  = imem_req_valid;
    s_inst       = inst;
    s_inst_pc    = inst_pc;
    if (imem_req_valid && imem_req_ready) begin
      checks++;
      if (pend) begin
        errors++;
        $display("FAIL req_overlap: request to %h accepted while another is outstanding", imem_req_addr);
      end
      checks++;
      if (imem_req_addr !== exp_pc) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_pc);
      end
      acc_addrs.push_back(imem_req_addr);
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = rand_mode ? int'($urandom_range(1, 4)) : rsp_delay;
    end
    if (redirect_valid) begin
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL redirect_gate: inst_valid got %b expected 0", inst_valid);
      end
    end
    if (inst_valid && inst_ready) begin
      want_inst  = misaligned(exp_pc) ? 32'd0 : data_fn(exp_pc);
      want_fault = misaligned(exp_pc) ? 1'b1 : err_fn(exp_pc);
      checks++;
      if (inst_pc !== exp_pc) begin
        errors++;
        $display("FAIL inst_pc: got %h expected %h", inst_pc, exp_pc);
      end
      checks++;
      if (inst !== want_inst) begin
        errors++;
        $display("FAIL inst_data: got %h expected %h (pc %h)", inst, want_inst, exp_pc);
      end
      checks++;
      if (inst_fault !== want_fault) begin
        errors++;
        $display("FAIL inst_fault: got %b expected %b (pc %h)", inst_fault, want_fault, exp_pc);
      end
      dlv_pcs.push_back(inst_pc);
      dlv_cyc.push_back(cyc);
      dlv_fault.push_back(inst_fault);
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = redirect_pc;
    @(posedge clk);
    cyc++;
  endtask

  task automatic wait_acc(input int n, input int budget, output bit ok);
    int k = 0;
    while (acc_addrs.size() <= n && k < budget) begin
      cycle();
      k++;
    end
    ok = (acc_addrs.size() > n);
  endtask

  task automatic wait_dlv(input int n, input int budget, output bit ok);
    int k = 0;
    while (dlv_pcs.size() < n && k < budget) begin
      cycle();
      k++;
    end
    ok = (dlv_pcs.size() >= n);
  endtask

  task automatic wait_out(input int budget, output bit ok);
    int k = 0;
    s_inst_valid = 1'b0;
    while (!s_inst_valid && k < budget) begin
      cycle();
      k++;
    end
    ok = s_inst_valid;
  endtask

  // Redirect from a held instruction in OUT, then resume with decode ready
  task automatic redirect_from_out(input logic [31:0] target, output bit ok);
    drv_inst_ready = 1'b0;
    wait_out(30, ok);
    drv_redirect    = 1'b1;
    drv_redirect_pc = target;
    drv_inst_ready  = 1'b1;
    cycle();
    drv_redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_req: valid %b addr %h expected 0 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== RESET_PC || inst_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_inst: valid %b inst %h pc %h fault %b", inst_valid, inst, inst_pc, inst_fault);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    bit ok;
    int start = cyc;
    drv_req_ready = 1'b1; drv_inst_ready = 1'b1; rsp_delay = 1;
    wait_dlv(3, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL seq_timeout: got %0d deliveries expected 3", dlv_pcs.size());
    end else begin
      checks++;
      if (acc_addrs[0] !== 32'h8000_0000 || acc_addrs[1] !== 32'h8000_0004 || acc_addrs[2] !== 32'h8000_0008) begin
        errors++;
        $display("FAIL seq_addrs: got %h %h %h", acc_addrs[0], acc_addrs[1], acc_addrs[2]);
      end
      checks++;
      if (dlv_cyc[0] - start !== 3) begin
        errors++;
        $display("FAIL seq_first_latency: got %0d cycles expected 3", dlv_cyc[0] - start);
      end
      checks++;
      if (dlv_cyc[2] - dlv_cyc[1] !== 3) begin
        errors++;
        $display("FAIL seq_rate: got %0d cycles between fetches expected 3", dlv_cyc[2] - dlv_cyc[1]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] snap_inst, snap_pc;
    int n, d;
    drv_inst_ready = 1'b0;
    wait_out(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: inst_valid got 0 expected 1");
    end
    snap_inst = s_inst; snap_pc = s_inst_pc; n = acc_addrs.size();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (s_inst_valid !== 1'b1 || s_inst !== snap_inst || s_inst_pc !== snap_pc || s_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid %b inst %h pc %h req %b expected 1 %h %h 0",
                 s_inst_valid, s_inst, s_inst_pc, s_req_valid, snap_inst, snap_pc);
      end
    end
    drv_inst_ready = 1'b1;
    d = dlv_pcs.size();
    cycle();
    checks++;
    if (dlv_pcs.size() !== d + 1) begin
      errors++;
      $display("FAIL stall_release: deliveries got %0d expected %0d", dlv_pcs.size(), d + 1);
    end
    wait_acc(n, 10, ok);
    checks++;
    if (acc_addrs.size() !== n + 1 || acc_addrs[$] !== snap_pc + 32'd4) begin
      errors++;
      $display("FAIL stall_next_req: count %0d addr %h expected %0d %h", acc_addrs.size(), acc_addrs[$], n + 1, snap_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok, saw_valid;
    int n, d, k;
    rsp_delay = 3; drv_inst_ready = 1'b1;
    n = acc_addrs.size();
    wait_acc(n, 20, ok);
    drv_redirect = 1'b1; drv_redirect_pc = 32'h8000_0100;
    d = dlv_pcs.size();
    cycle();
    drv_redirect = 1'b0;
    saw_valid = 1'b0; k = 0;
    while (acc_addrs.size() <= n + 1 && k < 20) begin
      cycle();
      if (s_inst_valid) saw_valid = 1'b1;
      k++;
    end
    checks++;
    if (saw_valid || dlv_pcs.size() !== d) begin
      errors++;
      $display("FAIL redir_wait_squash: inst_valid seen %b deliveries %0d expected 0 %0d", saw_valid, dlv_pcs.size(), d);
    end
    checks++;
    if (acc_addrs.size() !== n + 2 || acc_addrs[$] !== 32'h8000_0100) begin
      errors++;
      $display("FAIL redir_wait_addr: count %0d addr %h expected %0d 80000100", acc_addrs.size(), acc_addrs[$], n + 2);
    end
    rsp_delay = 1;
  endtask

  task automatic test_redirect_out();
    bit ok;
    int n;
    n = acc_addrs.size();
    redirect_from_out(32'h8000_0200, ok);
    checks++;
    if (!ok || s_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_out_gate: reached_out %b inst_valid %b expected 1 0", ok, s_inst_valid);
    end
    n = acc_addrs.size();
    wait_acc(n, 10, ok);
    checks++;
    if (!ok || acc_addrs[$] !== 32'h8000_0200) begin
      errors++;
      $display("FAIL redir_out_addr: got %h expected 80000200", acc_addrs[$]);
    end
  endtask

  task automatic test_fault();
    bit ok;
    redirect_from_out(32'h8000_0010, ok);
    wait_dlv(dlv_pcs.size() + 1, 20, ok);
    checks++;
    if (!ok || dlv_pcs[$] !== 32'h8000_0010 || dlv_fault[$] !== 1'b1) begin
      errors++;
      $display("FAIL fault_rsp: pc %h fault %b expected 80000010 1", dlv_pcs[$], dlv_fault[$]);
    end
`ifdef IFU_ALIGN_CHECK_EN
    begin
      int n;
      redirect_from_out(32'h8000_0002, ok);
      n = acc_addrs.size();
      wait_dlv(dlv_pcs.size() + 1, 20, ok);
      checks++;
      if (!ok || dlv_pcs[$] !== 32'h8000_0002 || dlv_fault[$] !== 1'b1 || acc_addrs.size() !== n) begin
        errors++;
        $display("FAIL fault_align: pc %h fault %b reqs %0d expected 80000002 1 %0d",
                 dlv_pcs[$], dlv_fault[$], acc_addrs.size(), n);
      end
    end
`endif
  endtask

  task automatic test_wrap();
    bit ok;
    int d;
    redirect_from_out(32'hFFFF_FFFC, ok);
    d = dlv_pcs.size();
    wait_dlv(d + 2, 30, ok);
    checks++;
    if (!ok || dlv_pcs[d] !== 32'hFFFF_FFFC || dlv_pcs[d + 1] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: deliveries %0d last pc %h expected 00000000", dlv_pcs.size(), dlv_pcs[$]);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int n;
    redirect_from_out(32'h8000_0300, ok);
    rsp_delay = 6;
    n = acc_addrs.size();
    wait_acc(n, 10, ok);
    cycle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0 ||
        inst !== 32'd0 || inst_pc !== RESET_PC || inst_fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req %b addr %h valid %b inst %h pc %h fault %b",
               imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault);
    end
    exp_pc = RESET_PC;
    pend_cnt = 3;
    cycle();
    cycle();
    #1 rst_n = 1'b1;
    rsp_delay = 1;
    n = acc_addrs.size();
    wait_acc(n, 10, ok);
    checks++;
    if (!ok || acc_addrs[$] !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_req: got %h expected %h", acc_addrs[$], RESET_PC);
    end
    wait_dlv(dlv_pcs.size() + 1, 20, ok);
    checks++;
    if (!ok || dlv_pcs[$] !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_inst: got %h expected %h", dlv_pcs[$], RESET_PC);
    end
  endtask

  task automatic test_random();
    int d = dlv_pcs.size();
    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    drv_redirect = 1'b0;
    checks++;
    if (dlv_pcs.size() - d < 100) begin
      errors++;
      $display("FAIL random_progress: got %0d deliveries expected at least 100", dlv_pcs.size() - d);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_fault();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
